// File: rtl/rep_seq_if.sv
// rep_seq_if: handshake bundle between a stimulus source and rep_seq_checker.
//   master drives en/start/a/stop and observes the results.
//   slave (the checker) observes en/start/a/stop and drives busy, pass, fail,
//   fail_code, drop, pass_cnt and fail_cnt.
interface rep_seq_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             start;
    logic             a;
    logic             stop;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic             drop;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    modport master (
        output en, start, a, stop,
        input  busy, pass, fail, fail_code, drop, pass_cnt, fail_cnt
    );
    modport slave (
        input  en, start, a, stop,
        output busy, pass, fail, fail_code, drop, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/rep_seq_checker.sv
// rep_seq_checker: run-time checker for $rose(start) ##PRE_DLY a[*REP_MIN:REP_MAX] ##1 stop.
//   clk, rst        clock and synchronous active-high reset
//   bus.en          1 = checking enabled, 0 = FSM forced to IDLE
//   bus.start       sequence trigger (rising edge)
//   bus.a, bus.stop repeated condition and terminator
//   bus.busy        FSM not in IDLE
//   bus.pass/fail   one-cycle result pulses, fail_code 1=SHORT 2=LONG 3=NOSTOP (held)
//   bus.drop        one-cycle pulse: rising start ignored while busy
//   bus.pass_cnt/fail_cnt saturating result counters
module rep_seq_checker #(
    parameter int PRE_DLY = 2,
    parameter int REP_MIN = 3,
    parameter int REP_MAX = 3,
    parameter int CNT_W   = 8
) (
    input logic      clk,
    input logic      rst,
    rep_seq_if.slave bus
);
    localparam int KW = $clog2(REP_MAX + 1);
    localparam int DW = $clog2(PRE_DLY + 1);
    localparam logic [KW-1:0] K_MIN  = KW'(REP_MIN);
    localparam logic [KW-1:0] K_MAX  = KW'(REP_MAX);
    localparam logic [DW-1:0] D_INIT = DW'(PRE_DLY - 1);
    localparam logic [DW-1:0] D_ONE  = DW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             start_q;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             drop_q, drop_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             go;

    assign go = bus.start & ~start_q & bus.en;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        code_d  = code_q;
        // A trigger seen while a sequence is in flight, including its deciding cycle, is lost.
        drop_d  = go & (state_q != IDLE);
        if (!bus.en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    state_d = (PRE_DLY == 1) ? CHECK : WAIT;
                    dcnt_d  = D_INIT;
                    k_d     = '0;
                end
                WAIT: begin
                    dcnt_d = dcnt_q - 1'b1;
                    if (dcnt_q == D_ONE) begin
                        state_d = CHECK;
                        k_d     = '0;
                    end
                end
                CHECK: begin
                    // stop outranks a once the minimum run is reached.
                    if (k_q >= K_MIN && bus.stop) begin
                        state_d = IDLE;
                        pass_d  = 1'b1;
                    end else if (bus.a && k_q < K_MAX) begin
                        k_d = k_q + 1'b1;
                    end else begin
                        state_d = IDLE;
                        fail_d  = 1'b1;
                        code_d  = (k_q < K_MIN) ? 2'd1 : (bus.a ? 2'd2 : 2'd3);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        pcnt_d = (pass_d && pcnt_q != '1) ? pcnt_q + 1'b1 : pcnt_q;
        fcnt_d = (fail_d && fcnt_q != '1) ? fcnt_q + 1'b1 : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            dcnt_q  <= '0;
            start_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            drop_q  <= 1'b0;
            code_q  <= 2'd0;
            pcnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            start_q <= bus.start;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            drop_q  <= drop_d;
            code_q  <= code_d;
            pcnt_q  <= pcnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.drop      = drop_q;
    assign bus.fail_code = code_q;
    assign bus.pass_cnt  = pcnt_q;
    assign bus.fail_cnt  = fcnt_q;
endmodule
